// File: rtl/apb_reg_dec.sv
// APB register decoder: RW register bank, RO status window and optional wait states.
// Optional feature: define APB_REG_DEC_STRB_EN to add the PSTRB byte-lane write strobe.
module apb_reg_dec #(
    parameter int AWIDTH           = 4,
    parameter int DWIDTH           = 32,
    parameter int REGWN            = 5,
    parameter int REGRN            = 3,
    parameter int REGR_ADDR_OFFSET = 5,
    parameter int WAIT_CYCLES      = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [AWIDTH-1:0]       PADDR,
    input  logic [DWIDTH-1:0]       PWDATA,
`ifdef APB_REG_DEC_STRB_EN
    input  logic [DWIDTH/8-1:0]     PSTRB,
`endif
    output logic [DWIDTH-1:0]       PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    output logic [REGWN*DWIDTH-1:0] rw_regs,
    input  logic [REGRN*DWIDTH-1:0] ro_vals,
    output logic [REGWN-1:0]        wr_pulse,
    output logic [REGRN-1:0]        rd_pulse
);

    localparam int          NBYTES    = DWIDTH / 8;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    generate
        if (REGRN > 0 && REGWN > 0 && REGR_ADDR_OFFSET < REGWN) begin : g_map_overlap
            $error("apb_reg_dec: RW and RO index ranges overlap");
        end
        if (DWIDTH % 8 != 0) begin : g_dwidth_bytes
            $error("apb_reg_dec: DWIDTH must be a multiple of 8");
        end
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_wait_range
            $error("apb_reg_dec: WAIT_CYCLES must be in 0..15");
        end
    endgenerate

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q;
    logic [AWIDTH-1:0]   addr_p1;
    logic                write_p1;
    logic [DWIDTH-1:0]   wdata_p1;
    logic [NBYTES-1:0]   strb_p1;
    logic [DWIDTH-1:0]   regs_q [REGWN];
    logic [DWIDTH-1:0]   rd_data;
    logic [31:0]         idx;
    logic                setup, complete, hit_rw, hit_ro, err;

    function automatic logic [DWIDTH-1:0] merge_bytes(input logic [DWIDTH-1:0] old_w,
                                                      input logic [DWIDTH-1:0] new_w,
                                                      input logic [NBYTES-1:0] strb);
        logic [DWIDTH-1:0] res;
        res = old_w;
        for (int b = 0; b < NBYTES; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return res;
    endfunction

    assign setup    = PSEL && !PENABLE;
    assign complete = PREADY && PSEL && PENABLE;
    assign idx      = 32'(addr_p1);
    assign hit_rw   = idx < 32'(REGWN);
    assign hit_ro   = (idx >= 32'(REGR_ADDR_OFFSET)) && (idx < 32'(REGR_ADDR_OFFSET + REGRN));
    // Writes into the RO window are rejected just like unmapped indices.
    assign err      = !(hit_rw || (hit_ro && !write_p1));

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && setup) begin
                cnt_q <= WAIT_INIT;
            end else if (state_q == ACCESS && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (setup) state_d = ACCESS;
            ACCESS:  if (!PSEL || complete) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        PREADY  = (state_q == ACCESS) && (cnt_q == 4'd0);
        PSLVERR = PREADY && err;
        PRDATA  = (PREADY && !err && !write_p1) ? rd_data : '0;
    end

    // Stage p1: transfer attributes captured at the setup edge.
    always_ff @(posedge PCLK) begin
        if (state_q == IDLE && setup) begin
            addr_p1  <= PADDR;
            write_p1 <= PWRITE;
            wdata_p1 <= PWDATA;
`ifdef APB_REG_DEC_STRB_EN
            strb_p1  <= PSTRB;
`endif
        end
    end

`ifdef APB_REG_DEC_STRB_EN
`else
    assign strb_p1 = '1;
`endif

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < REGWN; i++) begin
            if (idx == 32'(i)) rd_data = regs_q[i];
        end
        for (int j = 0; j < REGRN; j++) begin
            if (idx == 32'(REGR_ADDR_OFFSET + j)) rd_data = ro_vals[j*DWIDTH +: DWIDTH];
        end
    end

    // Stage commit: register update and side-effect pulses on the completion edge.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < REGWN; i++) regs_q[i] <= '0;
            wr_pulse <= '0;
            rd_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            rd_pulse <= '0;
            if (complete && !err) begin
                for (int i = 0; i < REGWN; i++) begin
                    if (write_p1 && idx == 32'(i)) begin
                        regs_q[i]   <= merge_bytes(regs_q[i], wdata_p1, strb_p1);
                        wr_pulse[i] <= 1'b1;
                    end
                end
                for (int j = 0; j < REGRN; j++) begin
                    if (!write_p1 && idx == 32'(REGR_ADDR_OFFSET + j)) rd_pulse[j] <= 1'b1;
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < REGWN; g++) begin : g_pack
            assign rw_regs[g*DWIDTH +: DWIDTH] = regs_q[g];
        end
    endgenerate

endmodule

// File: tb/tb_apb_reg_dec.sv
// Randomized bench for apb_reg_dec: a transaction-level model predicts every cycle's outputs.
// Define APB_REG_DEC_STRB_EN to also exercise byte strobes.
module tb_apb_reg_dec;

    localparam int AW   = 4;
    localparam int DW   = 32;
    localparam int RWN  = 5;
    localparam int RRN  = 3;
    localparam int ROFF = 5;
    localparam int WC   = 2;

    logic               PCLK = 1'b0;
    logic               PRESET, PSEL, PENABLE, PWRITE;
    logic [AW-1:0]      PADDR;
    logic [DW-1:0]      PWDATA;
    logic [DW/8-1:0]    strb_drv;
    logic [DW-1:0]      PRDATA;
    logic               PREADY, PSLVERR;
    logic [RWN*DW-1:0]  rw_regs;
    logic [RRN*DW-1:0]  ro_vals;
    logic [RWN-1:0]     wr_pulse;
    logic [RRN-1:0]     rd_pulse;

    apb_reg_dec #(
        .AWIDTH(AW), .DWIDTH(DW), .REGWN(RWN), .REGRN(RRN),
        .REGR_ADDR_OFFSET(ROFF), .WAIT_CYCLES(WC)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef APB_REG_DEC_STRB_EN
        .PSTRB(strb_drv),
`endif
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .rw_regs(rw_regs), .ro_vals(ro_vals), .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
    );

    always #5 PCLK = ~PCLK;

    logic [DW-1:0]  mregs [RWN];
    logic           exp_ready, exp_err;
    logic [DW-1:0]  exp_prdata;
    logic [RWN-1:0] exp_wr, pend_wr;
    logic [RRN-1:0] exp_rd, pend_rd;
    logic [DW-1:0]  pend_data;
    int             pend_idx;
    bit             chk_en, hold_ro;
    int             n_checks, n_errors;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_rw(input int idx);
        return idx < RWN;
    endfunction

    function automatic bit is_ro(input int idx);
        return idx >= ROFF && idx < ROFF + RRN;
    endfunction

    function automatic bit xfer_err(input bit wr, input int idx);
        return !(is_rw(idx) || (is_ro(idx) && !wr));
    endfunction

    function automatic logic [DW-1:0] model_read(input int idx);
        if (is_rw(idx)) return mregs[idx];
        if (is_ro(idx)) return ro_vals[(idx-ROFF)*DW +: DW];
        return '0;
    endfunction

    function automatic logic [DW-1:0] model_merge(input logic [DW-1:0] old_w,
                                                  input logic [DW-1:0] new_w,
                                                  input logic [DW/8-1:0] strb);
        logic [DW-1:0] r;
        logic [DW/8-1:0] m;
`ifdef APB_REG_DEC_STRB_EN
        m = strb;
`else
        m = '1;
`endif
        r = old_w;
        for (int b = 0; b < DW/8; b++) if (m[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [RWN*DW-1:0] model_pack();
        logic [RWN*DW-1:0] v;
        for (int i = 0; i < RWN; i++) v[i*DW +: DW] = mregs[i];
        return v;
    endfunction

    // Advance one clock; apply whatever the previous edge committed in the model.
    task automatic tick();
        @(posedge PCLK);
        #1;
        exp_wr = '0;
        exp_rd = '0;
        if (PRESET) begin
            for (int i = 0; i < RWN; i++) mregs[i] = '0;
        end else begin
            if (pend_wr != '0) mregs[pend_idx] = pend_data;
            exp_wr = pend_wr;
            exp_rd = pend_rd;
        end
        pend_wr = '0;
        pend_rd = '0;
        if (!hold_ro) ro_vals = {$urandom, $urandom, $urandom};
        exp_ready  = 1'b0;
        exp_err    = 1'b0;
        exp_prdata = '0;
    endtask

    task automatic idle_cycle();
        PSEL = 1'b0;
        PENABLE = 1'b0;
        tick();
    endtask

    task automatic stray_cycle();
        PSEL = 1'b1;
        PENABLE = 1'b1;
        PADDR = AW'($urandom_range(0, 15));
        tick();
        PSEL = 1'b0;
        PENABLE = 1'b0;
    endtask

    task automatic do_xfer(input bit wr, input int idx, input logic [DW-1:0] data,
                           input logic [DW/8-1:0] strb, input int abort_at, input int rst_at,
                           output int rdy_at, output logic [DW-1:0] rdata, output logic serr,
                           output logic [RWN-1:0] wp, output logic [RRN-1:0] rp);
        bit err;
        err    = xfer_err(wr, idx);
        rdy_at = -1;
        rdata  = '0;
        serr   = 1'b0;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = AW'(idx); PWDATA = data; strb_drv = strb;
        tick();
        for (int a = 0; a <= WC; a++) begin
            PENABLE    = 1'b1;
            PSEL       = (a != abort_at);
            PRESET     = (a == rst_at);
            exp_ready  = (a == WC);
            exp_err    = exp_ready && err;
            exp_prdata = (exp_ready && !err && !wr) ? model_read(idx) : '0;
            if (exp_ready && PSEL && !err) begin
                if (wr) begin
                    pend_idx  = idx;
                    pend_data = model_merge(mregs[idx], data, strb);
                    pend_wr   = RWN'(1) << idx;
                end else if (is_ro(idx)) begin
                    pend_rd = RRN'(1) << (idx - ROFF);
                end
            end
            @(negedge PCLK);
            if (PREADY && rdy_at < 0) rdy_at = a;
            if (a == WC) begin
                rdata = PRDATA;
                serr  = PSLVERR;
            end
            tick();
            if (a == abort_at || a == rst_at) break;
        end
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        wp = wr_pulse;
        rp = rd_pulse;
    endtask

    always @(negedge PCLK) begin
        if (chk_en) begin
            chk("PREADY", 256'(PREADY), 256'(exp_ready));
            chk("PSLVERR", 256'(PSLVERR), 256'(exp_err));
            chk("PRDATA", 256'(PRDATA), 256'(exp_prdata));
            chk("wr_pulse", 256'(wr_pulse), 256'(exp_wr));
            chk("rd_pulse", 256'(rd_pulse), 256'(exp_rd));
            chk("rw_regs", 256'(rw_regs), 256'(model_pack()));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int             rdy, r, ab, rs, idx;
        logic [DW-1:0]  rd;
        logic           se;
        logic [RWN-1:0] wp;
        logic [RRN-1:0] rp;
        bit             wr;

        n_checks = 0; n_errors = 0; chk_en = 1'b0; hold_ro = 1'b0;
        pend_wr = '0; pend_rd = '0; pend_idx = 0; pend_data = '0;
        for (int i = 0; i < RWN; i++) mregs[i] = 'x;
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; strb_drv = '1; ro_vals = '0;
        exp_ready = 1'b0; exp_err = 1'b0; exp_prdata = '0; exp_wr = '0; exp_rd = '0;
        tick();
        chk_en = 1'b1;
        chk("reset_rw_regs", 256'(rw_regs), 256'(0));
        tick();
        PRESET = 1'b0;
        idle_cycle();

        // Write idx 2 then read it back, back-to-back.
        do_xfer(1'b1, 2, 32'hDEADBEEF, 4'hF, -1, -1, rdy, rd, se, wp, rp);
        chk("wr2_ready_cycle", 256'(rdy), 256'(2));
        chk("wr2_pslverr", 256'(se), 256'(0));
        chk("wr2_pulse", 256'(wp), 256'(5'b00100));
        chk("wr2_reg", 256'(rw_regs[95:64]), 256'(32'hDEADBEEF));
        do_xfer(1'b0, 2, 32'h0, 4'hF, -1, -1, rdy, rd, se, wp, rp);
        chk("rd2_prdata", 256'(rd), 256'(32'hDEADBEEF));
        chk("rd2_no_pulse", 256'({wp, rp}), 256'(0));

        // RO read of index 6 with a pinned status value.
        hold_ro = 1'b1;
        ro_vals = {32'hCAFE0002, 32'h12345678, 32'hCAFE0000};
        do_xfer(1'b0, 6, 32'h0, 4'hF, -1, -1, rdy, rd, se, wp, rp);
        chk("rd6_ready_cycle", 256'(rdy), 256'(2));
        chk("rd6_prdata", 256'(rd), 256'(32'h12345678));
        chk("rd6_rd_pulse", 256'(rp), 256'(3'b010));
        hold_ro = 1'b0;

        // Error cases: write to RO, read unmapped.
        do_xfer(1'b1, 5, 32'h55AA55AA, 4'hF, -1, -1, rdy, rd, se, wp, rp);
        chk("wr5_pslverr", 256'(se), 256'(1));
        chk("wr5_no_pulse", 256'({wp, rp}), 256'(0));
        chk("wr5_regs_kept", 256'(rw_regs[95:64]), 256'(32'hDEADBEEF));
        do_xfer(1'b0, 9, 32'h0, 4'hF, -1, -1, rdy, rd, se, wp, rp);
        chk("rd9_pslverr", 256'(se), 256'(1));
        chk("rd9_prdata", 256'(rd), 256'(0));
        chk("rd9_no_pulse", 256'({wp, rp}), 256'(0));

        // Abort in the second access cycle.
        do_xfer(1'b1, 0, 32'h01020304, 4'hF, 1, -1, rdy, rd, se, wp, rp);
        chk("abort_no_ready", 256'(rdy), 256'(-1));
        chk("abort_reg0", 256'(rw_regs[31:0]), 256'(0));
        idle_cycle();

        // Back-to-back writes to idx 3 and 4.
        do_xfer(1'b1, 3, 32'hA5A5A5A5, 4'hF, -1, -1, rdy, rd, se, wp, rp);
        do_xfer(1'b1, 4, 32'h5A5A5A5A, 4'hF, -1, -1, rdy, rd, se, wp, rp);
        chk("b2b_pulse4", 256'(wp), 256'(5'b10000));
        chk("b2b_reg3", 256'(rw_regs[127:96]), 256'(32'hA5A5A5A5));
        chk("b2b_reg4", 256'(rw_regs[159:128]), 256'(32'h5A5A5A5A));

`ifdef APB_REG_DEC_STRB_EN
        do_xfer(1'b1, 1, 32'h11223344, 4'hF, -1, -1, rdy, rd, se, wp, rp);
        do_xfer(1'b1, 1, 32'hAABBCCDD, 4'b0101, -1, -1, rdy, rd, se, wp, rp);
        chk("strb_reg1", 256'(rw_regs[63:32]), 256'(32'h11BB33DD));
        do_xfer(1'b1, 1, 32'hFFFFFFFF, 4'b0000, -1, -1, rdy, rd, se, wp, rp);
        chk("strb0_pulse", 256'(wp), 256'(5'b00010));
        chk("strb0_reg1", 256'(rw_regs[63:32]), 256'(32'h11BB33DD));
`endif

        // Reset coincident with a write completion edge discards the write.
        do_xfer(1'b1, 1, 32'h77777777, 4'hF, -1, WC, rdy, rd, se, wp, rp);
        chk("rst_regs_zero", 256'(rw_regs), 256'(0));
        chk("rst_no_pulse", 256'(wp), 256'(0));
        idle_cycle();

        for (int t = 0; t < 400; t++) begin
            r = int'($urandom_range(0, 99));
            if (r < 5) stray_cycle();
            wr  = 1'($urandom_range(0, 1));
            idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 7));
            ab  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, WC-1)) : -1;
            rs  = (ab < 0 && $urandom_range(0, 29) == 0) ? int'($urandom_range(0, WC)) : -1;
            do_xfer(wr, idx, $urandom, 4'($urandom_range(0, 15)), ab, rs, rdy, rd, se, wp, rp);
            r = int'($urandom_range(0, 2));
            for (int k = 0; k < r; k++) idle_cycle();
        end

        idle_cycle();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_reg_dec.md
APB_REG_DEC -- requirements
Module: apb_reg_dec

Interface
REQ-001 Parameters SHALL be: AWIDTH, 4, PADDR width (word index); DWIDTH, 32, data width (multiple of 8); REGWN, 5, RW register count; REGRN, 3, RO register count; REGR_ADDR_OFFSET, 5, index of first RO register; WAIT_CYCLES, 0, wait states inserted before PREADY (0..15).
REQ-002 One clock, PCLK; reset is synchronous and active-high, PRESET.
REQ-003 PCLK  in  1  clock, all state updates on rising edge.
REQ-004 PRESET  in  1  synchronous active-high reset.
REQ-005 PSEL  in  1  slave select; PENABLE  in  1  access phase; PWRITE  in  1  1=write, 0=read.
REQ-006 PADDR  in  AWIDTH  register index; PWDATA  in  DWIDTH  write data.
REQ-007 PRDATA  out  DWIDTH  read data; PREADY  out  1  transfer complete; PSLVERR  out  1  transfer error.
REQ-008 rw_regs  out  REGWN*DWIDTH  RW register contents, register i at bits [i*DWIDTH +: DWIDTH].
REQ-009 ro_vals  in  REGRN*DWIDTH  RO status values, same packing, register j at index REGR_ADDR_OFFSET+j.
REQ-010 wr_pulse  out  REGWN  one-cycle pulse per RW register written; rd_pulse  out  REGRN  one-cycle pulse per RO register read.

Function
REQ-011 Map: index 0..REGWN-1 = RW; REGR_ADDR_OFFSET..REGR_ADDR_OFFSET+REGRN-1 = RO; all other indices unmapped; RW and RO ranges SHALL NOT overlap (elaboration check).
REQ-012 FSM states: IDLE, ACCESS; IDLE -> ACCESS on edge with PSEL=1, PENABLE=0 (setup), latching PADDR, PWRITE, PWDATA and loading wait counter with WAIT_CYCLES.
REQ-013 In ACCESS, counter decrements each cycle while nonzero; PREADY = (state==ACCESS && counter==0), so PREADY rises WAIT_CYCLES cycles after the first access cycle.
REQ-014 Completion edge = ACCESS with PREADY=1, PSEL=1, PENABLE=1; state -> IDLE; a setup in the following cycle starts a new transfer (back-to-back, no idle cycle required).
REQ-015 Write commit on completion edge to a mapped RW index: rw_regs[index] <= latched PWDATA; wr_pulse[index] high exactly the next cycle.
REQ-016 Read: while PREADY=1, PRDATA = rw_regs or ro_vals entry of latched index, sampled combinationally; PRDATA = 0 whenever PREADY=0 or PSLVERR=1.
REQ-017 RO read completion SHALL pulse rd_pulse[j] the next cycle (for clear-on-read logic outside).
REQ-018 PSLVERR=1 while PREADY=1 when latched index is unmapped or a write targets an RO index; no register change, no pulse.
REQ-019 PSEL=0 in ACCESS before completion: abort, state -> IDLE, no write, no pulse, no PREADY.
REQ-020 PSEL=1, PENABLE=1 seen in IDLE (no setup): ignored, stays IDLE.
REQ-021 PSLVERR, PREADY SHALL be 0 in IDLE.

Reset
REQ-022 PRESET=1 at an edge: state IDLE, counter 0, rw_regs all 0, wr_pulse 0, rd_pulse 0; PREADY, PSLVERR, PRDATA 0 the following cycle.
REQ-023 Reset mid-transfer SHALL discard the transfer with no register update, even when coincident with a completion edge.

Configuration
REQ-024 Macro APB_REG_DEC_STRB_EN defined: input PSTRB (DWIDTH/8) added, latched at setup; write updates only byte lanes with PSTRB bit 1; PSTRB=0 write completes without error and with wr_pulse.
REQ-025 APB_REG_DEC_STRB_EN undefined: no PSTRB port; all writes are full-word.

Verification
REQ-026 Defaults, WAIT_CYCLES=0: write idx 2 = 0xDEADBEEF -> PREADY in first access cycle, PSLVERR=0, rw_regs[2]=0xDEADBEEF, wr_pulse=5'b00100 one cycle; read idx 2 -> PRDATA=0xDEADBEEF.
REQ-027 WAIT_CYCLES=2: read RO idx 6 with ro_vals[1]=0x12345678 -> PREADY on third access cycle, PRDATA=0x12345678, rd_pulse=3'b010 one cycle.
REQ-028 Write idx 5 (RO) and read idx 9 (unmapped) -> PSLVERR=1, PRDATA=0, rw_regs unchanged, no pulses.
REQ-029 WAIT_CYCLES=3, write idx 0, PSEL dropped second access cycle -> no PREADY, rw_regs[0] stays 0; PRESET asserted mid write -> all rw_regs 0, state IDLE.
REQ-030 APB_REG_DEC_STRB_EN, rw_regs[1]=0x11223344, write 0xAABBCCDD PSTRB=4'b0101 -> rw_regs[1]=0x11BB33DD; back-to-back writes idx 3, 4 both commit.
